// File: rtl/flip_flop.sv
// Parameterised D register: WIDTH bits through STAGES cascaded flops, q = last stage (latency STAGES edges).
// Synchronous active-low reset loads RESET_VALUE into every stage; no backpressure, data advances every edge.
`timescale 1ns/1ps
module flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset clears the whole pipe on one edge so in-flight data is dropped together.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (!reset) begin
                stage_q[i] <= RESET_VALUE;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_flip_flop.sv
// Bench for flip_flop: default 1-bit/1-stage build and an 8-bit/3-stage build with reset value 8'hA5.
`timescale 1ns/1ps
module tb_flip_flop;

    logic       clk = 1'b0;
    logic       reset1 = 1'b0;
    logic       d1 = 1'b1;
    logic       q1;
    logic       reset8 = 1'b0;
    logic [7:0] d8 = 8'hFF;
    logic [7:0] q8;

    int errors = 0;
    int checks = 0;

    // Expected q after the next rising edge, one entry per edge per DUT.
    logic [7:0] e1[$];
    string      n1[$];
    logic [7:0] e8[$];
    string      n8[$];

    always #0.6 clk = ~clk;

    flip_flop dut1 (
        .clk   (clk),
        .reset (reset1),
        .d     (d1),
        .q     (q1)
    );

    flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .STAGES      (3)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
        .q     (q8)
    );

    logic [7:0] mon_exp;
    string      mon_name;

    // Monitor: q is presented after every rising edge; compare against the queued expectation.
    always @(posedge clk) begin
        #0.2;
        if (e1.size() > 0) begin
            mon_exp  = e1.pop_front();
            mon_name = n1.pop_front();
            checks++;
            if (q1 !== mon_exp[0]) begin
                errors++;
                $display("FAIL %s: q=%b expected %b", mon_name, q1, mon_exp[0]);
            end
        end
        if (e8.size() > 0) begin
            mon_exp  = e8.pop_front();
            mon_name = n8.pop_front();
            checks++;
            if (q8 !== mon_exp) begin
                errors++;
                $display("FAIL %s: q=%h expected %h", mon_name, q8, mon_exp);
            end
        end
    end

    task automatic push1(input logic e, input string nm);
        e1.push_back({7'd0, e});
        n1.push_back(nm);
    endtask

    task automatic push8(input logic [7:0] e, input string nm);
        e8.push_back(e);
        n8.push_back(nm);
    endtask

    // One clock cycle: just after the falling edge drive inputs and queue q expected after the next edge.
    task automatic cyc1(input logic r, input logic dv, input logic e, input string nm);
        @(posedge clk);
        #0.65;
        reset1 = r;
        d1     = dv;
        push1(e, nm);
    endtask

    task automatic cyc8(input logic r, input logic [7:0] dv, input logic [7:0] e, input string nm);
        @(posedge clk);
        #0.65;
        reset8 = r;
        d8     = dv;
        push8(e, nm);
    endtask

    initial begin
        // Reset held low while d changes.
        cyc1(1'b0, 1'b1, 1'b0, "rst_hold_d1_a");
        cyc1(1'b0, 1'b1, 1'b0, "rst_hold_d1_b");
        cyc1(1'b0, 1'b0, 1'b0, "rst_hold_d0_a");
        cyc1(1'b0, 1'b0, 1'b0, "rst_hold_d0_b");
        cyc1(1'b0, 1'b0, 1'b0, "rst_hold_d0_c");

        // Normal capture.
        cyc1(1'b0, 1'b1, 1'b0, "cap_rst_edge");
        cyc1(1'b1, 1'b1, 1'b1, "cap_one");
        cyc1(1'b1, 1'b0, 1'b0, "cap_zero");
        cyc1(1'b1, 1'b1, 1'b1, "cap_one_again");

        // d toggles 1->0->1 strictly between two edges.
        @(posedge clk);
        #0.3;
        d1 = 1'b0;
        #0.35;
        d1 = 1'b1;
        push1(1'b1, "inter_edge_toggle");
        cyc1(1'b1, 1'b1, 1'b1, "inter_edge_after");

        // Reset asserted just after an edge: q holds until the next edge.
        cyc1(1'b1, 1'b1, 1'b1, "sync_rst_pre");
        @(posedge clk);
        #0.1;
        reset1 = 1'b0;
        push1(1'b0, "sync_rst_edge");
        cyc1(1'b1, 1'b1, 1'b1, "sync_rst_release");

        // Reset pulse that does not span an edge.
        @(posedge clk);
        #0.3;
        reset1 = 1'b0;
        #0.35;
        reset1 = 1'b1;
        push1(1'b1, "rst_pulse_no_edge");
        cyc1(1'b1, 1'b0, 1'b0, "post_pulse_capture");

        // Wide, three-stage build.
        cyc8(1'b0, 8'hFF, 8'hA5, "w8_rst_a");
        cyc8(1'b0, 8'h00, 8'hA5, "w8_rst_b");
        cyc8(1'b1, 8'h3C, 8'hA5, "w8_lat_n");
        cyc8(1'b1, 8'h5A, 8'hA5, "w8_lat_n1");
        cyc8(1'b1, 8'hC3, 8'h3C, "w8_lat_n2");
        cyc8(1'b1, 8'h0F, 8'h5A, "w8_lat_n3");
        cyc8(1'b0, 8'hFF, 8'hA5, "w8_mid_rst");
        cyc8(1'b1, 8'h11, 8'hA5, "w8_flush_a");
        cyc8(1'b1, 8'h22, 8'hA5, "w8_flush_b");
        cyc8(1'b1, 8'h33, 8'h11, "w8_first_after_rst");
        cyc8(1'b1, 8'h44, 8'h22, "w8_second_after_rst");

        repeat (3) @(posedge clk);
        #0.5;
        checks++;
        if (e1.size() != 0 || e8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d required=0", e1.size() + e8.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000;
        $display("FAIL watchdog: time=%0t required finish before 1000ns", $time);
        $fatal(1);
    end

endmodule
